// File: rtl/vec_data_mem.sv
// vec_data_mem: byte-addressed data memory with a 32-bit scalar port (A)
// and a 128-bit vector port (B). Vector accesses that are not 16-byte
// aligned are split into two beats across consecutive lines, stalling
// port B for one extra cycle. Defining VMEM_BYPASS_EN forwards bytes
// written on the same edge to the reads of that edge.
module vec_data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr_a,
  input  logic          re_a,
  input  logic          we_a,
  input  logic [31:0]   wd_a,
  output logic [31:0]   rd_a,
  input  logic [AW-1:0] addr_b,
  input  logic          re_b,
  input  logic          we_b,
  input  logic [127:0]  data_b,
  output logic [127:0]  q_b,
  output logic          stall_b
);

  localparam int LW = $clog2(DEPTH);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t state, next_state;

  logic [7:0] mem [DEPTH][16];

  logic [LW-1:0]    line_a, line_b, cap_line, wb_line, rb_line;
  logic [1:0]       lane_a;
  logic [3:0]       off_b, cap_off, wr_off;
  logic             cap_wr, wa_en, req_b, rd_b_aligned;
  logic [3:0][7:0]  wd_vec, ra_view;
  logic [15:0][7:0] data_vec, cap_data, wr_src, wb_byte, rb_view, q_split;
  logic [15:0]      wb_en;
  logic             unused_addr_bits;

  assign line_a   = addr_a[LW+3:4];
  assign lane_a   = addr_a[3:2];
  assign line_b   = addr_b[LW+3:4];
  assign off_b    = addr_b[3:0];
  assign wd_vec   = wd_a;
  assign data_vec = data_b;
  assign req_b    = re_b | we_b;
  assign wa_en    = we_a & ~reset;
  assign rd_b_aligned = (state == IDLE) && re_b && !we_b && (off_b == 4'd0);
  assign unused_addr_bits = ^{addr_a[AW-1:LW+4], addr_a[1:0], addr_b[AW-1:LW+4]};

  // Split FSM: a misaligned request in IDLE stalls port B and moves to SPLIT for beat 2
  always_comb begin
    next_state = state;
    stall_b    = 1'b0;
    case (state)
      IDLE: begin
        if (req_b && off_b != 4'd0) begin
          stall_b    = 1'b1;
          next_state = SPLIT;
        end
      end
      SPLIT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Port B write beat: bytes off..15 of the request line in IDLE, bytes 0..off-1 of the next line in SPLIT
  always_comb begin
    wb_line = line_b;
    wr_src  = data_vec;
    wr_off  = off_b;
    wb_en   = '0;
    wb_byte = '0;
    if (state == SPLIT) begin
      wb_line = cap_line + LW'(1);
      wr_src  = cap_data;
      wr_off  = cap_off;
    end
    for (int i = 0; i < 16; i++) begin
      if (state == IDLE) wb_en[4'(i)] = we_b && !reset && (4'(i) >= off_b);
      else               wb_en[4'(i)] = cap_wr && !reset && (4'(i) < cap_off);
      wb_byte[4'(i)] = wr_src[4'(4'(i) - wr_off)];
    end
  end

  // Read views of the addressed bytes, optionally forwarding same-edge writes (port B has priority)
  always_comb begin
    rb_line = (state == IDLE) ? line_b : cap_line + LW'(1);
    for (int i = 0; i < 16; i++) begin
      rb_view[4'(i)] = mem[rb_line][4'(i)];
`ifdef VMEM_BYPASS_EN
      if (wa_en && line_a == rb_line && lane_a == 2'(i >> 2)) rb_view[4'(i)] = wd_vec[2'(i)];
      if (wb_en[4'(i)] && wb_line == rb_line) rb_view[4'(i)] = wb_byte[4'(i)];
`endif
    end
    for (int b = 0; b < 4; b++) begin
      ra_view[2'(b)] = mem[line_a][{lane_a, 2'(b)}];
`ifdef VMEM_BYPASS_EN
      if (wa_en) ra_view[2'(b)] = wd_vec[2'(b)];
      if (wb_en[{lane_a, 2'(b)}] && wb_line == line_a) ra_view[2'(b)] = wb_byte[{lane_a, 2'(b)}];
`endif
    end
  end

  // Assemble a split read: lanes below 16-off come from the captured first line, the rest from the next line
  always_comb begin
    q_split = '0;
    for (int j = 0; j < 16; j++) begin
      if ((5'(j) + 5'(cap_off)) >= 5'd16) q_split[4'(j)] = rb_view[4'(4'(j) + cap_off)];
      else                               q_split[4'(j)] = cap_data[4'(4'(j) + cap_off)];
    end
  end

  // Capture a misaligned request; a read keeps the first line's bytes so beat 2 only needs the next line
  always_ff @(posedge clk) begin
    if (state == IDLE && stall_b) begin
      cap_line <= line_b;
      cap_off  <= off_b;
      cap_wr   <= we_b;
      cap_data <= we_b ? data_vec : rb_view;
    end
  end

  // Memory array update: scalar bytes first so port B wins where both hit the same byte
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wa_en) mem[line_a][{lane_a, 2'(i)}] <= wd_vec[2'(i)];
    end
    for (int i = 0; i < 16; i++) begin
      if (wb_en[4'(i)]) mem[wb_line][4'(i)] <= wb_byte[4'(i)];
    end
  end

  // Registered read data for both ports; each holds its value when not reading
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_a <= '0;
      q_b  <= '0;
    end else begin
      if (re_a) rd_a <= ra_view;
      if (rd_b_aligned)                   q_b <= rb_view;
      else if (state == SPLIT && !cap_wr) q_b <= q_split;
    end
  end

endmodule

// File: tb/tb_vec_data_mem.sv
// tb_vec_data_mem: scoreboard bench for vec_data_mem. Expected read data
// comes from a byte-level reference memory and is queued with the cycle
// the DUT should present it. Honours VMEM_BYPASS_EN for the collision case.
module tb_vec_data_mem;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr_a, wd_a, rd_a, addr_b;
  logic         re_a, we_a, re_b, we_b, stall_b;
  logic [127:0] data_b, q_b;

  vec_data_mem #(.DEPTH(256), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .addr_a(addr_a), .re_a(re_a), .we_a(we_a), .wd_a(wd_a), .rd_a(rd_a),
    .addr_b(addr_b), .re_b(re_b), .we_b(we_b), .data_b(data_b), .q_b(q_b),
    .stall_b(stall_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] val;
    int           due;
    bit           vec;
    int           id;
  } exp_t;

  exp_t         sb[$];
  logic [7:0]   ref_mem [256][16];
  logic [127:0] last_q;
  int           checks = 0;
  int           failures = 0;
  int           cycle = 0;
  int           next_id = 0;

  function automatic logic [7:0] ref_rd(input logic [11:0] a);
    return ref_mem[a[11:4]][a[3:0]];
  endfunction

  function automatic void ref_wr(input logic [11:0] a, input logic [7:0] d);
    ref_mem[a[11:4]][a[3:0]] = d;
  endfunction

  function automatic logic [127:0] ref_vec(input logic [11:0] a);
    logic [127:0] v;
    for (int j = 0; j < 16; j++) v[8*j +: 8] = ref_rd(a + 12'(j));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [11:0] a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_rd({a[11:2], 2'b00} + 12'(b));
    return w;
  endfunction

  function automatic logic [127:0] pat(input logic [7:0] base);
    logic [127:0] v;
    for (int j = 0; j < 16; j++) v[8*j +: 8] = base + 8'(j);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic pushExp(input logic [127:0] val, input int lat, input bit vec);
    exp_t e;
    e.val = val;
    e.due = cycle + lat;
    e.vec = vec;
    e.id  = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  // Compare every queued expectation that falls due after the current edge
  task automatic drain();
    for (int i = 0; i < sb.size(); ) begin
      if (sb[i].due == cycle) begin
        if (sb[i].vec) checkOutput($sformatf("sb_q_b#%0d", sb[i].id), q_b, sb[i].val);
        else           checkOutput($sformatf("sb_rd_a#%0d", sb[i].id), {96'b0, rd_a}, sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic wa, input logic [31:0] aa,
                               input logic [31:0] da, input logic rb, input logic wb,
                               input logic [31:0] ab, input logic [127:0] db,
                               input logic rst, input logic exp_stall, input string tag);
    reset  = rst;
    re_a   = ra;  we_a = wa;  addr_a = aa;  wd_a = da;
    re_b   = rb;  we_b = wb;  addr_b = ab;  data_b = db;
    #1;
    checkOutput({tag, "_stall"}, {127'b0, stall_b}, {127'b0, exp_stall});
    @(posedge clk);
    #1;
    cycle++;
    drain();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, "idle");
  endtask

  task automatic vwrite(input logic [31:0] a, input logic [127:0] d);
    bit mis = (a[3:0] != 4'd0);
    for (int j = 0; j < 16; j++) ref_wr(a[11:0] + 12'(j), d[8*j +: 8]);
    applyStimulus(0, 0, 0, 0, 0, 1, a, d, 0, mis, "vwr");
    if (mis) applyStimulus(0, 0, 0, 0, 0, 1, a, d, 0, 0, "vwr_beat2");
  endtask

  task automatic vread(input logic [31:0] a);
    bit mis = (a[3:0] != 4'd0);
    last_q = ref_vec(a[11:0]);
    pushExp(last_q, mis ? 2 : 1, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 0, a, '0, 0, mis, "vrd");
    if (mis) applyStimulus(0, 0, 0, 0, 1, 0, a, '0, 0, 0, "vrd_beat2");
  endtask

  task automatic swrite(input logic [31:0] a, input logic [31:0] d);
    for (int b = 0; b < 4; b++) ref_wr({a[11:2], 2'b00} + 12'(b), d[8*b +: 8]);
    applyStimulus(0, 1, a, d, 0, 0, 0, '0, 0, 0, "swr");
  endtask

  task automatic sread(input logic [31:0] a);
    pushExp({96'b0, ref_word(a[11:0])}, 1, 1'b0);
    applyStimulus(1, 0, a, 0, 0, 0, 0, '0, 0, 0, "srd");
  endtask

  initial begin
    logic [31:0] old_w, new_w;
    last_q = '0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, '0, 1, 0, "rst");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, '0, 1, 0, "rst");
    checkOutput("rst_rd_a", {96'b0, rd_a}, '0);
    checkOutput("rst_q_b", q_b, '0);
    checkOutput("rst_stall", {127'b0, stall_b}, '0);

    // Aligned vector write then read
    vwrite(32'h20, pat(8'h00));
    vread(32'h20);

    // Scalar write into a vector line, read back both ways
    swrite(32'h28, 32'hDEADBEEF);
    vread(32'h20);
    sread(32'h28);

    // Misaligned read across lines 2 and 3, scalar read issued during SPLIT
    vwrite(32'h20, pat(8'h20));
    vwrite(32'h30, pat(8'h30));
    last_q = ref_vec(12'h025);
    pushExp(last_q, 2, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h25, '0, 0, 1, "mis_rd");
    pushExp({96'b0, ref_word(12'h034)}, 1, 1'b0);
    applyStimulus(1, 0, 32'h34, 0, 1, 0, 32'h25, '0, 0, 0, "mis_rd_beat2");
    idle();

    // Wrap-around split write from line 255 into line 0
    vwrite(32'hFF0, pat(8'hF0));
    vwrite(32'h000, pat(8'h50));
    vwrite(32'hFFC, pat(8'hA0));
    vread(32'hFF0);
    vread(32'h000);
    vread(32'hFFC);

    // Reset during SPLIT of a misaligned write: beat 2 must not land
    vwrite(32'h40, pat(8'h60));
    vwrite(32'h50, pat(8'h70));
    vread(32'h40);
    for (int j = 0; j < 15; j++) ref_wr(12'h041 + 12'(j), 8'hC0 + 8'(j));
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h41, pat(8'hC0), 0, 1, "rst_split");
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h41, pat(8'hC0), 1, 0, "rst_split_beat2");
    last_q = '0;
    checkOutput("rst_split_q_b", q_b, '0);
    idle();
    vread(32'h50);
    vread(32'h40);

    // Same-cycle scalar read and vector write of the same bytes
    old_w = ref_word(12'h024);
    for (int j = 0; j < 16; j++) ref_wr(12'h020 + 12'(j), 8'hB0 + 8'(j));
    new_w = ref_word(12'h024);
`ifdef VMEM_BYPASS_EN
    pushExp({96'b0, new_w}, 1, 1'b0);
`else
    pushExp({96'b0, old_w}, 1, 1'b0);
`endif
    applyStimulus(1, 0, 32'h24, 0, 0, 1, 32'h20, pat(8'hB0), 0, 0, "collide");
    vread(32'h20);

    // Same-edge scalar and vector writes: overlapping then non-overlapping bytes
    vwrite(32'h70, pat(8'h10));
    vwrite(32'h80, pat(8'h90));
    for (int b = 0; b < 4; b++) ref_wr(12'h034 + 12'(b), 8'h11 * 8'(b + 1));
    for (int j = 0; j < 16; j++) ref_wr(12'h030 + 12'(j), 8'hE0 + 8'(j));
    applyStimulus(0, 1, 32'h34, 32'h44332211, 0, 1, 32'h30, pat(8'hE0), 0, 0, "ovl");
    vread(32'h30);
    for (int b = 0; b < 4; b++) ref_wr(12'h070 + 12'(b), 8'h55 + 8'(b));
    for (int j = 0; j < 16; j++) ref_wr(12'h07C + 12'(j), 8'hD0 + 8'(j));
    applyStimulus(0, 1, 32'h70, 32'h58575655, 0, 1, 32'h7C, pat(8'hD0), 0, 1, "novl");
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h7C, pat(8'hD0), 0, 0, "novl_beat2");
    vread(32'h70);
    vread(32'h80);

    // re_b and we_b together: a write, q_b keeps its previous value
    for (int j = 0; j < 16; j++) ref_wr(12'h090 + 12'(j), 8'h33 + 8'(j));
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h90, pat(8'h33), 0, 0, "rw");
    checkOutput("rw_q_hold", q_b, last_q);
    vread(32'h90);

    idle();
    idle();
    checkOutput("sb_empty", 128'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
